// File: rtl/upc_loop_monitor.sv
// Passive performance monitor for one HLS pipelined loop.
// Counts transactions, iterations, stalls, in-flight depth and latency.
module upc_loop_monitor #(
    parameter int STATE_W = 8,
    parameter int CNT_W   = 32,
    parameter int DEPTH   = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [STATE_W-1:0]           cur_state,
    input  logic [STATE_W-1:0]           iter_start_state,
    input  logic [STATE_W-1:0]           iter_end_state,
    input  logic [STATE_W-1:0]           quit_state,
    input  logic                         iter_start_block,
    input  logic                         iter_end_block,
    input  logic                         quit_block,
    input  logic                         iter_start_enable,
    input  logic                         iter_end_enable,
    input  logic                         quit_enable,
    input  logic                         loop_start,
    input  logic                         loop_ready,
    input  logic                         loop_done,
    input  logic                         loop_continue,
    input  logic                         quit_at_end,
    input  logic                         finish,
    output logic                         busy,
    output logic [CNT_W-1:0]             txn_count,
    output logic [CNT_W-1:0]             iter_start_count,
    output logic [CNT_W-1:0]             iter_end_count,
    output logic [CNT_W-1:0]             stall_cycles,
    output logic [CNT_W-1:0]             busy_cycles,
    output logic [$clog2(DEPTH+1)-1:0]   in_flight,
    output logic [CNT_W-1:0]             last_latency,
    output logic [CNT_W-1:0]             max_latency,
    output logic                         frozen,
    output logic                         error
);

    localparam int IFW = $clog2(DEPTH+1);
    localparam logic [IFW-1:0] DEPTH_V = IFW'(DEPTH);

    typedef enum logic {IDLE, RUN} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] txn_q, txn_d;
    logic [CNT_W-1:0] isc_q, isc_d;
    logic [CNT_W-1:0] iec_q, iec_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] bcyc_q, bcyc_d;
    logic [CNT_W-1:0] lat_q, lat_d;
    logic [CNT_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] max_q, max_d;
    logic [IFW-1:0]   inf_q, inf_d;
    logic             frozen_q, frozen_d;
    logic             err_q, err_d;

    logic s_ev, e_ev, q_ev, d_ev, stall_ev;
    logic in_run, start_acc, done_acc, done_err;
    logic [CNT_W-1:0] cur_lat;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        s_ev = (cur_state == iter_start_state) && !iter_start_block
               && iter_start_enable;
        e_ev = (cur_state == iter_end_state) && !iter_end_block
               && iter_end_enable;
        q_ev = (cur_state == quit_state) && !quit_block
               && quit_enable && quit_at_end;
        d_ev = loop_done && loop_continue;
        stall_ev = ((cur_state == iter_start_state) && iter_start_block)
                || ((cur_state == iter_end_state) && iter_end_block)
                || ((cur_state == quit_state) && quit_block);
        in_run    = (state_q == RUN);
        // A start is taken from IDLE, or from RUN when it rides on a completion.
        start_acc = loop_start && (!in_run || d_ev);
        done_acc  = d_ev && (in_run || loop_start);
        done_err  = d_ev && !in_run && !loop_start;
        cur_lat   = in_run ? lat_q : CNT_W'(1);
    end

    always_comb begin
        state_d  = state_q;
        txn_d    = txn_q;
        isc_d    = isc_q;
        iec_d    = iec_q;
        stall_d  = stall_q;
        bcyc_d   = bcyc_q;
        lat_d    = lat_q;
        last_d   = last_q;
        max_d    = max_q;
        inf_d    = inf_q;
        err_d    = err_q;
        frozen_d = frozen_q || finish;

        if (!frozen_q && !finish) begin
            case (state_q)
                IDLE:    if (loop_start && !d_ev) state_d = RUN;
                RUN:     if (d_ev && !loop_start) state_d = IDLE;
                default: state_d = IDLE;
            endcase

            if (start_acc)   lat_d = CNT_W'(1);
            else if (in_run) lat_d = sat_inc(lat_q);

            if (done_acc) begin
                txn_d  = sat_inc(txn_q);
                last_d = cur_lat;
                if (cur_lat > max_q) max_d = cur_lat;
            end
            if (done_err) err_d = 1'b1;

            if (s_ev) isc_d = sat_inc(isc_q);
            if (e_ev) iec_d = sat_inc(iec_q);

            if (s_ev && !e_ev) begin
                if (inf_q == DEPTH_V) err_d = 1'b1;
                else                  inf_d = inf_q + IFW'(1);
            end else if (e_ev && !s_ev) begin
                if (inf_q == '0) err_d = 1'b1;
                else             inf_d = inf_q - IFW'(1);
            end

            // Only the iteration retiring this cycle may be left at quit.
            if (q_ev && (int'(inf_q) - int'(e_ev) > 1)) err_d = 1'b1;

            if (in_run) begin
                bcyc_d = sat_inc(bcyc_q);
                if (stall_ev) stall_d = sat_inc(stall_q);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            txn_q    <= '0;
            isc_q    <= '0;
            iec_q    <= '0;
            stall_q  <= '0;
            bcyc_q   <= '0;
            lat_q    <= '0;
            last_q   <= '0;
            max_q    <= '0;
            inf_q    <= '0;
            frozen_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            txn_q    <= txn_d;
            isc_q    <= isc_d;
            iec_q    <= iec_d;
            stall_q  <= stall_d;
            bcyc_q   <= bcyc_d;
            lat_q    <= lat_d;
            last_q   <= last_d;
            max_q    <= max_d;
            inf_q    <= inf_d;
            frozen_q <= frozen_d;
            err_q    <= err_d;
        end
    end

    assign busy             = (state_q == RUN);
    assign txn_count        = txn_q;
    assign iter_start_count = isc_q;
    assign iter_end_count   = iec_q;
    assign stall_cycles     = stall_q;
    assign busy_cycles      = bcyc_q;
    assign in_flight        = inf_q;
    assign last_latency     = last_q;
    assign max_latency      = max_q;
    assign frozen           = frozen_q;
    assign error            = err_q;

    logic unused_ok;
    assign unused_ok = loop_ready;

endmodule

// File: tb/tb_upc_loop_monitor.sv
// Directed scoreboard bench for upc_loop_monitor.
// Expectations are queued at drive time and checked after the next edge.
module tb_upc_loop_monitor;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  cur_state, iter_start_state, iter_end_state, quit_state;
    logic        iter_start_block, iter_end_block, quit_block;
    logic        iter_start_enable, iter_end_enable, quit_enable;
    logic        loop_start, loop_ready, loop_done, loop_continue;
    logic        quit_at_end, finish;
    logic        busy, frozen, error;
    logic [31:0] txn_count, iter_start_count, iter_end_count;
    logic [31:0] stall_cycles, busy_cycles, last_latency, max_latency;
    logic [2:0]  in_flight;

    int n_asserts = 0;
    int n_fail    = 0;

    upc_loop_monitor #(.STATE_W(8), .CNT_W(32), .DEPTH(4)) dut (
        .clock(clock), .reset(reset),
        .cur_state(cur_state),
        .iter_start_state(iter_start_state),
        .iter_end_state(iter_end_state),
        .quit_state(quit_state),
        .iter_start_block(iter_start_block),
        .iter_end_block(iter_end_block),
        .quit_block(quit_block),
        .iter_start_enable(iter_start_enable),
        .iter_end_enable(iter_end_enable),
        .quit_enable(quit_enable),
        .loop_start(loop_start), .loop_ready(loop_ready),
        .loop_done(loop_done), .loop_continue(loop_continue),
        .quit_at_end(quit_at_end), .finish(finish),
        .busy(busy), .txn_count(txn_count),
        .iter_start_count(iter_start_count),
        .iter_end_count(iter_end_count),
        .stall_cycles(stall_cycles), .busy_cycles(busy_cycles),
        .in_flight(in_flight), .last_latency(last_latency),
        .max_latency(max_latency), .frozen(frozen), .error(error)
    );

    always #5 clock = ~clock;

    typedef enum {TXN, ISC, IEC, STL, BCY, INF, LAST, MAXL,
                  BUSY, FROZ, ERR} sel_e;
    typedef struct {
        sel_e        sel;
        logic [31:0] val;
        string       tag;
    } sb_t;
    sb_t sb[$];

    function automatic logic [31:0] obs(input sel_e s);
        case (s)
            TXN:     return txn_count;
            ISC:     return iter_start_count;
            IEC:     return iter_end_count;
            STL:     return stall_cycles;
            BCY:     return busy_cycles;
            INF:     return 32'(in_flight);
            LAST:    return last_latency;
            MAXL:    return max_latency;
            BUSY:    return 32'(busy);
            FROZ:    return 32'(frozen);
            default: return 32'(error);
        endcase
    endfunction

    task automatic ex(input sel_e s, input logic [31:0] v, input string t);
        sb_t e;
        e.sel = s;
        e.val = v;
        e.tag = t;
        sb.push_back(e);
    endtask

    task automatic check_now();
        sb_t e;
        logic [31:0] o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs(e.sel);
            n_asserts++;
            assert (o === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %0d expected %0d", e.tag, o, e.val);
            end
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        check_now();
    endtask

    task automatic ex_zero(input string t);
        ex(TXN, 0, {t, "_txn"});
        ex(ISC, 0, {t, "_isc"});
        ex(IEC, 0, {t, "_iec"});
        ex(STL, 0, {t, "_stall"});
        ex(BCY, 0, {t, "_bcyc"});
        ex(INF, 0, {t, "_inflight"});
        ex(LAST, 0, {t, "_last"});
        ex(MAXL, 0, {t, "_max"});
        ex(BUSY, 0, {t, "_busy"});
        ex(FROZ, 0, {t, "_frozen"});
        ex(ERR, 0, {t, "_error"});
    endtask

    task automatic drv(input logic st, input logic s, input logic e,
                       input logic d, input logic blk);
        loop_start        = st;
        iter_start_enable = s;
        iter_end_enable   = e;
        loop_done         = d;
        iter_start_block  = blk;
    endtask

    task automatic do_reset(input string t);
        reset       = 1'b0;
        drv(0, 0, 0, 0, 0);
        quit_enable = 1'b0;
        finish      = 1'b0;
        #2;
        ex_zero(t);
        check_now();
        step();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        cur_state = '0; iter_start_state = '0;
        iter_end_state = '0; quit_state = '0;
        iter_start_block = 0; iter_end_block = 0; quit_block = 0;
        iter_start_enable = 0; iter_end_enable = 0; quit_enable = 0;
        loop_start = 0; loop_ready = 0; loop_done = 0; loop_continue = 0;
        quit_at_end = 0; finish = 0;
        do_reset("rst0");

        cur_state = 8'h02; iter_start_state = 8'h02;
        iter_end_state = 8'h02; quit_state = 8'h02;
        loop_continue = 1'b1; quit_at_end = 1'b1;

        // 8 iterations, E lags S by 3, done at cycle 12
        drv(1, 0, 0, 0, 0);
        ex(BUSY, 1, "t1_busy_start");
        step();
        for (int c = 1; c <= 12; c++) begin
            drv(0, c <= 8, c >= 4 && c <= 11, c == 12, 0);
            if (c == 3)  ex(INF, 3, "t1_inflight_peak");
            if (c == 8)  ex(INF, 3, "t1_inflight_steady");
            if (c == 11) ex(INF, 0, "t1_inflight_end");
            if (c == 12) begin
                ex(TXN, 1, "t1_txn");
                ex(ISC, 8, "t1_isc");
                ex(IEC, 8, "t1_iec");
                ex(LAST, 12, "t1_last");
                ex(MAXL, 12, "t1_max");
                ex(BCY, 12, "t1_bcyc");
                ex(STL, 0, "t1_stall");
                ex(BUSY, 0, "t1_busy_end");
                ex(ERR, 0, "t1_error");
            end
            step();
        end
        drv(0, 0, 0, 0, 0);
        step();

        // same loop with a 2-cycle start-stage stall
        drv(1, 0, 0, 0, 0);
        step();
        for (int c = 1; c <= 14; c++) begin
            drv(0, c <= 10, c >= 6 && c <= 13, c == 14, c == 3 || c == 4);
            if (c == 4) ex(ISC, 10, "t2_isc_blocked");
            if (c == 5) ex(INF, 3, "t2_inflight");
            if (c == 14) begin
                ex(ISC, 16, "t2_isc");
                ex(IEC, 16, "t2_iec");
                ex(STL, 2, "t2_stall");
                ex(TXN, 2, "t2_txn");
                ex(LAST, 14, "t2_last");
                ex(BCY, 26, "t2_bcyc");
                ex(INF, 0, "t2_inflight_end");
            end
            step();
        end

        // back-to-back transactions of latency 5 and 9
        do_reset("rst1");
        for (int c = 0; c <= 14; c++) begin
            drv(c == 0 || c == 5, 0, 0, c == 5 || c == 14, 0);
            if (c < 14) ex(BUSY, 1, $sformatf("t3_busy_c%0d", c));
            if (c == 5) begin
                ex(TXN, 1, "t3_txn1");
                ex(LAST, 5, "t3_last1");
            end
            if (c == 14) begin
                ex(TXN, 2, "t3_txn2");
                ex(LAST, 9, "t3_last2");
                ex(MAXL, 9, "t3_max");
                ex(BCY, 14, "t3_bcyc");
                ex(BUSY, 0, "t3_busy_end");
            end
            step();
        end

        // E with nothing in flight
        drv(0, 0, 1, 0, 0);
        ex(ERR, 1, "t4_err_underflow");
        ex(INF, 0, "t4_inflight_hold");
        ex(IEC, 1, "t4_iec");
        step();
        drv(0, 0, 0, 0, 0);
        step();
        ex(ERR, 1, "t4_err_sticky");
        step();

        // single-cycle txn is legal, bare done in IDLE is not
        do_reset("rst2");
        drv(1, 0, 0, 1, 0);
        ex(ERR, 0, "t5_single_ok");
        ex(TXN, 1, "t5_single_txn");
        ex(LAST, 1, "t5_single_lat");
        ex(BUSY, 0, "t5_single_busy");
        step();
        drv(0, 0, 0, 1, 0);
        ex(ERR, 1, "t5_done_idle_err");
        ex(TXN, 1, "t5_done_idle_txn");
        step();

        // quit with two iterations still in flight
        do_reset("rst3");
        drv(1, 0, 0, 0, 0);
        step();
        drv(0, 1, 0, 0, 0);
        step();
        ex(INF, 2, "t6_inflight");
        ex(ERR, 0, "t6_err_before");
        step();
        drv(0, 0, 0, 0, 0);
        quit_enable = 1'b1;
        ex(ERR, 1, "t6_quit_err");
        step();
        quit_enable = 1'b0;

        // finish freezes everything
        do_reset("rst4");
        drv(1, 0, 0, 0, 0);
        step();
        for (int c = 1; c <= 3; c++) begin
            drv(0, 1, 0, 0, 0);
            step();
        end
        drv(0, 0, 0, 0, 0);
        finish = 1'b1;
        ex(FROZ, 1, "t7_frozen");
        ex(ISC, 3, "t7_isc_at_finish");
        step();
        finish = 1'b0;
        for (int c = 0; c < 5; c++) begin
            drv(0, 1, 0, c == 4, 0);
            step();
        end
        drv(0, 0, 0, 0, 0);
        ex(ISC, 3, "t7_isc_frozen");
        ex(INF, 3, "t7_inflight_frozen");
        ex(TXN, 0, "t7_txn_frozen");
        ex(BUSY, 1, "t7_busy_frozen");
        ex(FROZ, 1, "t7_frozen_held");
        step();

        // asynchronous reset between edges
        #3;
        reset = 1'b0;
        #1;
        ex_zero("t7_async");
        check_now();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asserts, n_fail);
        $finish;
    end

endmodule
